cordic_vector: RTL and testbench

CORDIC_VECTOR -- requirements
Module: cordic_vector

---
 rtl/cordic_vector_if.sv | 21 ++
 rtl/cordic_vector.sv | 143 ++++++++++++++
 tb/tb_cordic_vector.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vector_if.sv
// Request/result bundle for the CORDIC vectoring engine.
// The master drives the operands and start; the slave returns angle, magnitude and status.
interface cordic_vector_if;
  logic               start_i;
  logic signed [15:0] x_i;
  logic signed [15:0] y_i;
  logic signed [15:0] angle_o;
  logic        [15:0] mag_o;
  logic               busy_o;
  logic               done_o;

  modport master (
    output start_i, x_i, y_i,
    input  angle_o, mag_o, busy_o, done_o
  );

  modport slave (
    input  start_i, x_i, y_i,
    output angle_o, mag_o, busy_o, done_o
  );
endinterface

// File: rtl/cordic_vector.sv
// Iterative CORDIC in vectoring mode: rotates (x,y) onto the x axis, one micro-rotation
// per clock, returning atan2(y,x) as a binary angle and the gain-corrected magnitude.
module cordic_vector #(
  parameter int ITER = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  cordic_vector_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_SCALE
  } state_t;

  localparam logic [15:0] ATAN_TABLE [16] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
  };
  localparam logic [16:0] INV_GAIN  = 17'd39797;
  localparam logic [3:0]  LAST_STEP = 4'(ITER - 1);

  state_t             state_q, state_d;
  logic signed [17:0] x_q, x_d;
  logic signed [17:0] y_q, y_d;
  logic        [15:0] z_q, z_d;
  logic        [3:0]  cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic        [15:0] angle_q, angle_d;
  logic        [15:0] mag_q, mag_d;
  logic               done_q, done_d;

  logic signed [17:0] x_ext;
  logic signed [17:0] y_ext;
  logic signed [17:0] x_shift;
  logic signed [17:0] y_shift;
  logic        [15:0] atan_step;
  logic        [16:0] x_pos;
  logic        [17:0] mag_scaled;
  logic        [15:0] mag_sat;

  assign x_ext     = {{2{bus.x_i[15]}}, bus.x_i};
  assign y_ext     = {{2{bus.y_i[15]}}, bus.y_i};
  assign x_shift   = x_q >>> cnt_q;
  assign y_shift   = y_q >>> cnt_q;
  assign atan_step = ATAN_TABLE[cnt_q];

  // x is never negative after preconditioning; clamp anyway so the multiplier stays unsigned.
  assign x_pos      = x_q[17] ? 17'd0 : x_q[16:0];
  assign mag_scaled = 18'((34'(x_pos) * 34'(INV_GAIN)) >> 16);
  assign mag_sat    = (|mag_scaled[17:16]) ? 16'hFFFF : mag_scaled[15:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_ITER;
          cnt_d   = '0;
          // A zero vector has no defined angle; the iterations would otherwise sum the table.
          zero_d  = (bus.x_i == 16'sd0) && (bus.y_i == 16'sd0);
          if (bus.x_i[15]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = 16'h8000;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = 16'h0000;
          end
        end
      end

      ST_ITER: begin
        if (!y_q[17]) begin
          x_d = x_q + y_shift;
          y_d = y_q - x_shift;
          z_d = z_q + atan_step;
        end else begin
          x_d = x_q - y_shift;
          y_d = y_q + x_shift;
          z_d = z_q - atan_step;
        end
        if (cnt_q == LAST_STEP) begin
          state_d = ST_SCALE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_SCALE: begin
        state_d = ST_IDLE;
        angle_d = zero_q ? 16'h0000 : z_q;
        mag_d   = mag_sat;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.angle_o = angle_q;
  assign bus.mag_o   = mag_q;
  assign bus.done_o  = done_q;
  assign bus.busy_o  = (state_q != ST_IDLE) || done_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Directed and random checks of cordic_vector against an ideal atan2/sqrt reference,
// with expected results queued at start and matched when the block reports done.
module tb_cordic_vector;

  localparam int  ITER = 16;
  localparam real PI   = 3.14159265358979323846;

  typedef struct {
    int          xv;
    int          yv;
    int          acc;
    logic [15:0] exp_ang;
    real         exp_mag;
    bit          exact;
    bit          chk;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  cordic_vector_if bus ();

  cordic_vector #(.ITER(ITER)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_fail   = 0;
  int   n_cmp    = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  exp_t               mon_e;
  logic signed [15:0] ang_err;
  real                mag_err;
  real                mag_tol;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [15:0] ideal_angle(input int xv, input int yv);
    real a;
    int  r;
    a = $atan2(real'(yv), real'(xv)) * 32768.0 / PI;
    r = $rtoi((a >= 0.0) ? a + 0.5 : a - 0.5);
    return 16'(r);
  endfunction

  // Result checker: every done pulse must match the oldest outstanding request.
  always @(negedge clk_i) begin
    if (bus.done_o === 1'b1) begin
      done_cnt++;
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_done obs=done_with_no_request exp=no_done");
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        n_cmp++;
        assert ((cyc - mon_e.acc) === ITER + 1) else begin
          n_fail++;
          $error("FAIL latency x=%0d y=%0d obs=%0d exp=%0d", mon_e.xv, mon_e.yv, cyc - mon_e.acc, ITER + 1);
        end
        n_cmp++;
        assert (bus.busy_o === 1'b1) else begin
          n_fail++;
          $error("FAIL busy_in_done obs=%b exp=1", bus.busy_o);
        end
        if (mon_e.exact) begin
          n_cmp++;
          assert (bus.angle_o === mon_e.exp_ang) else begin
            n_fail++;
            $error("FAIL zero_angle obs=%0d exp=%0d", bus.angle_o, $signed(mon_e.exp_ang));
          end
          n_cmp++;
          assert (bus.mag_o === 16'd0) else begin
            n_fail++;
            $error("FAIL zero_mag obs=%0d exp=0", bus.mag_o);
          end
        end else if (mon_e.chk) begin
          ang_err = bus.angle_o - $signed(mon_e.exp_ang);
          mag_err = real'(bus.mag_o) - mon_e.exp_mag;
          mag_tol = 2.0 + 0.001 * mon_e.exp_mag;
          n_cmp++;
          assert (ang_err >= -16'sd4 && ang_err <= 16'sd4) else begin
            n_fail++;
            $error("FAIL angle x=%0d y=%0d obs=%0d exp=%0d", mon_e.xv, mon_e.yv, bus.angle_o, $signed(mon_e.exp_ang));
          end
          n_cmp++;
          assert (mag_err <= mag_tol && mag_err >= -mag_tol) else begin
            n_fail++;
            $error("FAIL mag x=%0d y=%0d obs=%0d exp=%0.2f", mon_e.xv, mon_e.yv, bus.mag_o, mon_e.exp_mag);
          end
        end
      end
    end
  end

  // Called on a falling edge; start is seen by the next rising edge.
  task automatic drive(input int xv, input int yv, input bit accepted);
    exp_t e;
    bus.start_i = 1'b1;
    bus.x_i     = 16'(xv);
    bus.y_i     = 16'(yv);
    n_vec++;
    if (accepted) begin
      e.xv      = xv;
      e.yv      = yv;
      e.acc     = cyc + 1;
      e.exp_ang = ideal_angle(xv, yv);
      e.exp_mag = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
      e.exact   = (xv == 0) && (yv == 0);
      // Short vectors lose angle resolution to integer truncation in y.
      e.chk     = e.exp_mag >= 8192.0;
      sb.push_back(e);
    end
    @(negedge clk_i);
    bus.start_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk_i);
    n_cmp++;
    assert (sb.size() === 0) else begin
      n_fail++;
      $error("FAIL drain_timeout obs=%0d_pending exp=0_pending", sb.size());
    end
  endtask

  task automatic run_one(input int xv, input int yv);
    @(negedge clk_i);
    drive(xv, yv, 1'b1);
    n_cmp++;
    assert (bus.busy_o === 1'b1) else begin
      n_fail++;
      $error("FAIL busy_after_accept obs=%b exp=1", bus.busy_o);
    end
    drain();
  endtask

  task automatic check_cleared(input string tag);
    n_cmp++;
    assert (bus.angle_o === 16'sd0) else begin
      n_fail++;
      $error("FAIL %s_angle obs=%0d exp=0", tag, bus.angle_o);
    end
    n_cmp++;
    assert (bus.mag_o === 16'd0) else begin
      n_fail++;
      $error("FAIL %s_mag obs=%0d exp=0", tag, bus.mag_o);
    end
    n_cmp++;
    assert (bus.busy_o === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_busy obs=%b exp=0", tag, bus.busy_o);
    end
    n_cmp++;
    assert (bus.done_o === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_done obs=%b exp=0", tag, bus.done_o);
    end
  endtask

  initial begin
    int d0;
    int xv;
    int yv;

    rst_i       = 1'b1;
    bus.start_i = 1'b0;
    bus.x_i     = '0;
    bus.y_i     = '0;

    // Reset state, with start held high to show reset wins.
    repeat (2) @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.x_i     = 16'sd1234;
    @(negedge clk_i);
    check_cleared("reset");
    bus.start_i = 1'b0;
    rst_i       = 1'b0;

    // Directed operands, including the -32768 corners.
    run_one(16384, 0);
    run_one(0, 16384);
    run_one(10000, 10000);
    run_one(-16384, 0);
    run_one(-16384, -1);
    run_one(0, 0);
    run_one(-32768, 0);
    run_one(-32768, -32768);
    run_one(0, -32768);
    run_one(32767, -32768);
    run_one(-20000, 25000);

    // A second start mid-conversion must be ignored.
    d0 = done_cnt;
    @(negedge clk_i);
    drive(20000, -5000, 1'b1);
    repeat (4) @(negedge clk_i);
    drive(-7000, 3000, 1'b0);
    drain();
    repeat (ITER + 4) @(negedge clk_i);
    n_cmp++;
    assert ((done_cnt - d0) === 1) else begin
      n_fail++;
      $error("FAIL ignored_start_dones obs=%0d exp=1", done_cnt - d0);
    end

    // Back-to-back: new start presented in the done cycle.
    @(negedge clk_i);
    drive(15000, 15000, 1'b1);
    for (int i = 0; i < 100 && bus.done_o !== 1'b1; i++) @(negedge clk_i);
    n_cmp++;
    assert (bus.done_o === 1'b1) else begin
      n_fail++;
      $error("FAIL b2b_done_timeout obs=%b exp=1", bus.done_o);
    end
    drive(-25000, -9000, 1'b1);
    drain();

    // Reset at iteration 8 aborts the conversion.
    @(negedge clk_i);
    drive(12000, 9000, 1'b1);
    repeat (8) @(negedge clk_i);
    sb.delete();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_cleared("abort");
    d0 = done_cnt;
    repeat (ITER + 4) @(negedge clk_i);
    n_cmp++;
    assert (done_cnt === d0) else begin
      n_fail++;
      $error("FAIL abort_done obs=%0d exp=%0d", done_cnt, d0);
    end

    // Fresh conversion after the abort.
    run_one(-12345, 23456);

    // Random sweep.
    for (int k = 0; k < 1000; k++) begin
      xv = ($urandom_range(0, 15) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      yv = ($urandom_range(0, 15) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
      run_one(xv, yv);
    end

    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
